// File: rtl/tlu_dut_trigger_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tlu_dut_trigger_rx_if                                             |
// | Brief  : Trigger-number valid/ready stream from the TLU responder to the   |
// |          DUT readout.                                                      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface tlu_dut_trigger_rx_if #(
  parameter int TRIGGER_BITS = 16
);
  logic [TRIGGER_BITS-1:0] TRIGGER_NUMBER;
  logic                    TRIGGER_VALID;
  logic                    TRIGGER_READY;

  modport master (
    output TRIGGER_NUMBER,
    output TRIGGER_VALID,
    input  TRIGGER_READY
  );

  modport slave (
    input  TRIGGER_NUMBER,
    input  TRIGGER_VALID,
    output TRIGGER_READY
  );
endinterface
`default_nettype wire

// File: rtl/tlu_dut_trigger_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tlu_dut_trigger_rx                                                |
// | Brief  : DUT-side TLU trigger/busy responder with optional data handshake  |
// |          (TLU_CLOCK generation and MSB-first trigger-number shift-in).     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tlu_dut_trigger_rx #(
  parameter int TRIGGER_BITS   = 16,
  parameter int CLK_DIV_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     ENABLE,
  input  logic                     CONF_DATA_HANDSHAKE,
  input  logic [CLK_DIV_WIDTH-1:0] CONF_CLK_DIV,
  input  logic                     DUT_HOLD,
  input  logic                     TLU_TRIGGER,
  output logic                     TLU_BUSY,
  output logic                     TLU_CLOCK,
  tlu_dut_trigger_rx_if.master     trig_bus,
  output logic [31:0]              TRIGGER_COUNT,
  output logic [7:0]               TIMEOUT_ERR_COUNT
);

  localparam int c_TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int c_BIT_W = (TRIGGER_BITS > 1) ? $clog2(TRIGGER_BITS) : 1;

  localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(TRIGGER_BITS - 1);
  localparam logic [CLK_DIV_WIDTH-1:0] c_DIV_MIN = CLK_DIV_WIDTH'(3);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_WAIT_LOW = 3'd1;
  localparam logic [2:0] c_SHIFT    = 3'd2;
  localparam logic [2:0] c_OUTPUT   = 3'd3;
  localparam logic [2:0] c_RELEASE  = 3'd4;
  localparam logic [2:0] c_ERR_WAIT = 3'd5;

  logic [2:0]               r_state;
  logic [2:0]               w_state_nxt;
  logic                     r_trig_meta;
  logic                     r_trig_s;
  logic                     r_trig_prev;
  logic                     w_trig_rise;
  logic                     r_data_mode;
  logic [c_TO_W-1:0]        r_to_cnt;
  logic [CLK_DIV_WIDTH-1:0] r_div;
  logic [CLK_DIV_WIDTH-1:0] r_phase_cnt;
  logic                     r_clk_high;
  logic [c_BIT_W-1:0]       r_bit_cnt;
  logic [TRIGGER_BITS-1:0]  r_number;
  logic [31:0]              r_local_cnt;
  logic [31:0]              r_trig_count;
  logic [7:0]               r_err_count;
  logic                     w_phase_end;
  logic [CLK_DIV_WIDTH-1:0] w_div_eff;
  logic                     w_busy;
  logic                     w_valid;
  logic                     w_tclk;

  // TLU_TRIGGER is asynchronous to CLK; only r_trig_s is used by the logic.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_trig_meta <= 1'b0;
      r_trig_s    <= 1'b0;
      r_trig_prev <= 1'b0;
    end else begin
      r_trig_meta <= TLU_TRIGGER;
      r_trig_s    <= r_trig_meta;
      r_trig_prev <= r_trig_s;
    end
  end

  assign w_trig_rise = r_trig_s & ~r_trig_prev;
  assign w_phase_end = (r_phase_cnt == r_div);
  assign w_div_eff   = (CONF_CLK_DIV < c_DIV_MIN) ? c_DIV_MIN : CONF_CLK_DIV;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_trig_rise && ENABLE) w_state_nxt = c_WAIT_LOW;
      end
      c_WAIT_LOW: begin
        if (!r_trig_s) begin
          w_state_nxt = r_data_mode ? c_SHIFT : c_OUTPUT;
        end else if (r_data_mode && (r_to_cnt == c_TO_LAST)) begin
          w_state_nxt = c_ERR_WAIT;
        end
      end
      c_SHIFT: begin
        if (w_phase_end && !r_clk_high && (r_bit_cnt == c_BIT_LAST)) w_state_nxt = c_OUTPUT;
      end
      c_OUTPUT: begin
        if (trig_bus.TRIGGER_READY) w_state_nxt = c_RELEASE;
      end
      c_RELEASE, c_ERR_WAIT: begin
        if (!DUT_HOLD && !r_trig_s) w_state_nxt = c_IDLE;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_busy  = 1'b1;
    w_valid = 1'b0;
    w_tclk  = 1'b0;
    case (r_state)
      c_IDLE:   w_busy  = 1'b0;
      c_SHIFT:  w_tclk  = r_clk_high;
      c_OUTPUT: w_valid = 1'b1;
      default:  w_busy  = 1'b1;
    endcase
  end

  // Mode is captured every IDLE cycle so the value at the accepting edge sticks.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_data_mode  <= 1'b0;
      r_to_cnt     <= '0;
      r_div        <= '0;
      r_phase_cnt  <= '0;
      r_clk_high   <= 1'b0;
      r_bit_cnt    <= '0;
      r_number     <= '0;
      r_local_cnt  <= '0;
      r_trig_count <= '0;
      r_err_count  <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_data_mode <= CONF_DATA_HANDSHAKE;
          r_to_cnt    <= '0;
        end
        c_WAIT_LOW: begin
          r_to_cnt <= r_to_cnt + 1'b1;
          if (w_state_nxt == c_SHIFT) begin
            r_div       <= w_div_eff;
            r_phase_cnt <= '0;
            r_clk_high  <= 1'b1;
            r_bit_cnt   <= '0;
          end
          if (w_state_nxt == c_OUTPUT) begin
            r_number    <= r_local_cnt[TRIGGER_BITS-1:0];
            r_local_cnt <= r_local_cnt + 32'd1;
          end
          if ((w_state_nxt == c_ERR_WAIT) && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
          end
        end
        c_SHIFT: begin
          if (w_phase_end) begin
            r_phase_cnt <= '0;
            r_clk_high  <= ~r_clk_high;
            if (r_clk_high) begin
              r_number <= {r_number[TRIGGER_BITS-2:0], r_trig_s};
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else begin
            r_phase_cnt <= r_phase_cnt + 1'b1;
          end
        end
        c_OUTPUT: begin
          if (trig_bus.TRIGGER_READY) r_trig_count <= r_trig_count + 32'd1;
        end
        default: begin
          r_to_cnt <= '0;
        end
      endcase
    end
  end

  assign TLU_BUSY                = w_busy;
  assign TLU_CLOCK               = w_tclk;
  assign trig_bus.TRIGGER_VALID  = w_valid;
  assign trig_bus.TRIGGER_NUMBER = r_number;
  assign TRIGGER_COUNT           = r_trig_count;
  assign TIMEOUT_ERR_COUNT       = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_tlu_dut_trigger_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_tlu_dut_trigger_rx                                             |
// | Brief  : Scoreboard bench for tlu_dut_trigger_rx with a TLU-side model.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_tlu_dut_trigger_rx;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        ENABLE;
  logic        CONF_DATA_HANDSHAKE;
  logic [7:0]  CONF_CLK_DIV;
  logic        DUT_HOLD;
  logic        TLU_TRIGGER;
  logic        TLU_BUSY;
  logic        TLU_CLOCK;
  logic [31:0] TRIGGER_COUNT;
  logic [7:0]  TIMEOUT_ERR_COUNT;

  tlu_dut_trigger_rx_if #(.TRIGGER_BITS(16)) trig_bus ();

  tlu_dut_trigger_rx #(
    .TRIGGER_BITS   (16),
    .CLK_DIV_WIDTH  (8),
    .TIMEOUT_CYCLES (1024)
  ) dut (
    .CLK                 (CLK),
    .RESET_N             (RESET_N),
    .ENABLE              (ENABLE),
    .CONF_DATA_HANDSHAKE (CONF_DATA_HANDSHAKE),
    .CONF_CLK_DIV        (CONF_CLK_DIV),
    .DUT_HOLD            (DUT_HOLD),
    .TLU_TRIGGER         (TLU_TRIGGER),
    .TLU_BUSY            (TLU_BUSY),
    .TLU_CLOCK           (TLU_CLOCK),
    .trig_bus            (trig_bus),
    .TRIGGER_COUNT       (TRIGGER_COUNT),
    .TIMEOUT_ERR_COUNT   (TIMEOUT_ERR_COUNT)
  );

  always #5 CLK = ~CLK;

  int          n_cmp;
  int          n_bad;
  logic [15:0] exp_q[$];
  int unsigned local_model;
  int unsigned exp_xfers;
  int unsigned exp_err;
  int          exp_half;
  int          tclk_rises;
  int          valid_cycles;
  bit          width_skip;
  bit          mon_on;
  bit          ready_rand;
  logic        ready_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer READY: changes 2 ns after the rising edge, either fixed or random.
  initial begin
    trig_bus.TRIGGER_READY = 1'b0;
    forever begin
      @(posedge CLK);
      #2;
      trig_bus.TRIGGER_READY = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  // Scoreboard monitor: pops on every VALID&READY, checks stability under backpressure.
  initial begin
    logic [15:0] held;
    logic [15:0] e;
    bit          pending;
    pending = 1'b0;
    held    = '0;
    forever begin
      @(negedge CLK);
      if (mon_on && RESET_N === 1'b1) begin
        if (trig_bus.TRIGGER_VALID === 1'b1) begin
          valid_cycles++;
          if (pending) check("valid_number_stable", 32'(trig_bus.TRIGGER_NUMBER), 32'(held));
          held    = trig_bus.TRIGGER_NUMBER;
          pending = (trig_bus.TRIGGER_READY !== 1'b1);
          if (trig_bus.TRIGGER_READY === 1'b1) begin
            if (exp_q.size() == 0) begin
              check("unexpected_valid", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              check("trigger_number", 32'(trig_bus.TRIGGER_NUMBER), 32'(e));
            end
          end
        end else begin
          if (pending) check("valid_dropped_without_ready", 32'd0, 32'd1);
          pending = 1'b0;
        end
      end else begin
        pending = 1'b0;
      end
    end
  end

  // TLU_CLOCK monitor: counts pulses and checks high/low phase lengths.
  initial begin
    logic prev;
    int   run;
    prev = 1'b0;
    run  = 0;
    forever begin
      @(negedge CLK);
      if (TLU_CLOCK === prev) begin
        run++;
      end else begin
        if (mon_on && !width_skip) begin
          if (prev === 1'b1) check("tlu_clock_high_len", 32'(run), 32'(exp_half));
          else if (tclk_rises > 0) check("tlu_clock_low_len", 32'(run), 32'(exp_half));
        end
        if (TLU_CLOCK === 1'b1) tclk_rises++;
        run = 1;
      end
      prev = TLU_CLOCK;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // All stimulus tasks start and end on a falling CLK edge.
  task automatic raise_trig();
    TLU_TRIGGER = 1'b1;
    repeat (2) @(negedge CLK);
    check("busy_before_3rd_edge", 32'(TLU_BUSY), 32'd0);
    @(negedge CLK);
    check("busy_at_3rd_edge", 32'(TLU_BUSY), 32'd1);
  endtask

  task automatic wait_busy_low(input int budget);
    int n;
    n = 0;
    while (TLU_BUSY !== 1'b0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (TLU_BUSY !== 1'b0) check("busy_release_timeout", 32'(TLU_BUSY), 32'd0);
  endtask

  task automatic wait_q_empty(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0) check("handshake_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_tclk(input logic lvl, output bit ok);
    int n;
    n = 0;
    while (TLU_CLOCK !== lvl && n < 100) begin
      @(negedge CLK);
      n++;
    end
    ok = (TLU_CLOCK === lvl);
    if (!ok) check("tlu_clock_wait_timeout", 32'(TLU_CLOCK), 32'(lvl));
  endtask

  task automatic simple_txn(input int hi);
    CONF_DATA_HANDSHAKE = 1'b0;
    exp_q.push_back(16'(local_model));
    local_model++;
    exp_xfers++;
    valid_cycles = 0;
    tclk_rises   = 0;
    raise_trig();
    repeat (hi - 3) @(negedge CLK);
    TLU_TRIGGER = 1'b0;
  endtask

  // TLU side of a data handshake; abort_bit >= 0 pulses RESET_N while that bit's clock is high.
  task automatic data_txn(input logic [15:0] num, input int div, input int abort_bit);
    bit ok;
    CONF_DATA_HANDSHAKE = 1'b1;
    CONF_CLK_DIV        = 8'(div);
    exp_half     = ((div < 3) ? 3 : div) + 1;
    width_skip   = 1'b0;
    tclk_rises   = 0;
    valid_cycles = 0;
    if (abort_bit < 0) begin
      exp_q.push_back(num);
      exp_xfers++;
    end
    raise_trig();
    CONF_DATA_HANDSHAKE = 1'($urandom_range(0, 1));
    TLU_TRIGGER = 1'b0;
    for (int b = 0; b < 16; b++) begin
      wait_tclk(1'b1, ok);
      if (!ok) return;
      if (b == 0) CONF_CLK_DIV = 8'($urandom_range(0, 255));
      if (b == abort_bit) begin
        width_skip  = 1'b1;
        RESET_N     = 1'b0;
        TLU_TRIGGER = 1'b0;
        @(negedge CLK);
        check("reset_tlu_clock", 32'(TLU_CLOCK), 32'd0);
        check("reset_busy", 32'(TLU_BUSY), 32'd0);
        check("reset_valid", 32'(trig_bus.TRIGGER_VALID), 32'd0);
        check("reset_number", 32'(trig_bus.TRIGGER_NUMBER), 32'd0);
        check("reset_count", TRIGGER_COUNT, 32'd0);
        RESET_N     = 1'b1;
        local_model = 0;
        exp_xfers   = 0;
        exp_err     = 0;
        return;
      end
      TLU_TRIGGER = num[15 - b];
      wait_tclk(1'b0, ok);
      if (!ok) return;
    end
    TLU_TRIGGER = 1'b0;
  endtask

  initial begin
    int mode;
    int hc;
    n_cmp = 0; n_bad = 0;
    local_model = 0; exp_xfers = 0; exp_err = 0;
    exp_half = 4; tclk_rises = 0; valid_cycles = 0;
    width_skip = 1'b0; mon_on = 1'b0; ready_rand = 1'b0; ready_val = 1'b1;
    RESET_N = 1'b0; ENABLE = 1'b1; CONF_DATA_HANDSHAKE = 1'b0; CONF_CLK_DIV = 8'd3;
    DUT_HOLD = 1'b0; TLU_TRIGGER = 1'b0;
    repeat (4) @(negedge CLK);
    check("rst_busy", 32'(TLU_BUSY), 32'd0);
    check("rst_tlu_clock", 32'(TLU_CLOCK), 32'd0);
    check("rst_valid", 32'(trig_bus.TRIGGER_VALID), 32'd0);
    check("rst_number", 32'(trig_bus.TRIGGER_NUMBER), 32'd0);
    check("rst_count", TRIGGER_COUNT, 32'd0);
    check("rst_err_count", 32'(TIMEOUT_ERR_COUNT), 32'd0);
    RESET_N = 1'b1;
    mon_on  = 1'b1;
    repeat (3) @(negedge CLK);

    // Simple mode, three pulses with READY high.
    for (int i = 0; i < 3; i++) begin
      simple_txn(10);
      wait_q_empty(200);
      wait_busy_low(50);
      check("simple_one_cycle_valid", 32'(valid_cycles), 32'd1);
      repeat (36) @(negedge CLK);
    end
    check("count_after_simple", TRIGGER_COUNT, 32'(exp_xfers));

    // Data mode, 0xA5C3 with half-period 4.
    data_txn(16'hA5C3, 3, -1);
    wait_q_empty(200);
    wait_busy_low(50);
    check("data_tlu_clock_pulses", 32'(tclk_rises), 32'd16);
    check("count_after_data", TRIGGER_COUNT, 32'(exp_xfers));
    repeat (5) @(negedge CLK);

    // Backpressure, hold extension and an ignored trigger during RELEASE.
    ready_val = 1'b0;
    DUT_HOLD  = 1'b1;
    simple_txn(10);
    repeat (100) @(negedge CLK);
    check("backpressure_valid_held", 32'(trig_bus.TRIGGER_VALID), 32'd1);
    ready_val = 1'b1;
    wait_q_empty(20);
    repeat (5) @(negedge CLK);
    TLU_TRIGGER = 1'b1;
    repeat (4) @(negedge CLK);
    TLU_TRIGGER = 1'b0;
    repeat (11) @(negedge CLK);
    check("busy_held_by_dut_hold", 32'(TLU_BUSY), 32'd1);
    DUT_HOLD = 1'b0;
    @(negedge CLK);
    check("busy_drop_after_hold", 32'(TLU_BUSY), 32'd0);
    check("count_after_backpressure", TRIGGER_COUNT, 32'(exp_xfers));
    repeat (10) @(negedge CLK);

    // Data-mode timeout: TRIGGER held for 2000 cycles.
    CONF_DATA_HANDSHAKE = 1'b1;
    tclk_rises   = 0;
    valid_cycles = 0;
    raise_trig();
    repeat (1997) @(negedge CLK);
    TLU_TRIGGER = 1'b0;
    exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    repeat (2) @(negedge CLK);
    check("err_busy_held", 32'(TLU_BUSY), 32'd1);
    @(negedge CLK);
    check("err_busy_fall_3", 32'(TLU_BUSY), 32'd0);
    check("err_count", 32'(TIMEOUT_ERR_COUNT), 32'(exp_err));
    check("err_no_tlu_clock", 32'(tclk_rises), 32'd0);
    check("err_no_valid", 32'(valid_cycles), 32'd0);
    check("err_count_unchanged_xfers", TRIGGER_COUNT, 32'(exp_xfers));
    repeat (5) @(negedge CLK);

    // Reset during SHIFT, then a full transaction.
    data_txn(16'(($urandom_range(0, 65535))), 3, 7);
    repeat (5) @(negedge CLK);
    check("post_reset_err_count", 32'(TIMEOUT_ERR_COUNT), 32'(exp_err));
    data_txn(16'h5A3C, 4, -1);
    wait_q_empty(200);
    wait_busy_low(50);
    check("post_reset_pulses", 32'(tclk_rises), 32'd16);
    check("post_reset_count", TRIGGER_COUNT, 32'(exp_xfers));
    repeat (5) @(negedge CLK);

    // ENABLE low across the trigger edge: no transaction.
    ENABLE = 1'b0;
    CONF_DATA_HANDSHAKE = 1'b0;
    TLU_TRIGGER = 1'b1;
    repeat (6) @(negedge CLK);
    ENABLE = 1'b1;
    repeat (10) @(negedge CLK);
    check("disabled_no_busy", 32'(TLU_BUSY), 32'd0);
    TLU_TRIGGER = 1'b0;
    repeat (5) @(negedge CLK);
    check("disabled_no_busy_after", 32'(TLU_BUSY), 32'd0);
    simple_txn(10);
    wait_q_empty(200);
    wait_busy_low(50);
    check("enable_next_accepted", TRIGGER_COUNT, 32'(exp_xfers));
    repeat (5) @(negedge CLK);

    // Randomized mix of modes, dividers, READY patterns and hold times.
    ready_rand = 1'b1;
    for (int i = 0; i < 12; i++) begin
      mode     = int'($urandom_range(0, 1));
      hc       = int'($urandom_range(0, 15));
      DUT_HOLD = 1'($urandom_range(0, 1));
      if (mode == 1) data_txn(16'($urandom_range(0, 65535)), int'($urandom_range(0, 6)), -1);
      else           simple_txn(int'($urandom_range(4, 20)));
      wait_q_empty(500);
      repeat (hc) @(negedge CLK);
      DUT_HOLD = 1'b0;
      wait_busy_low(60);
      check("rand_tlu_clock_pulses", 32'(tclk_rises), (mode == 1) ? 32'd16 : 32'd0);
      repeat (int'($urandom_range(2, 10))) @(negedge CLK);
    end
    ready_rand = 1'b0;
    repeat (5) @(negedge CLK);
    check("final_count", TRIGGER_COUNT, 32'(exp_xfers));
    check("final_err_count", 32'(TIMEOUT_ERR_COUNT), 32'(exp_err));
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
